// File: rtl/mem_bus_initiator.sv
// Memory-bus initiator: read bursts and write-fill bursts on the 14-bit address / 16-bit data bus.
// Optional abort input enabled by defining MEM_BUS_INITIATOR_ABORT_EN.
module mem_bus_initiator #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned LEN_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_rstn,
`ifdef MEM_BUS_INITIATOR_ABORT_EN
   input  logic             i_abort,
`endif
   input  logic             i_cmdValid,
   output logic             o_cmdReady,
   input  logic             i_cmdWrite,
   input  logic [13:0]      i_cmdAddr,
   input  logic [15:0]      i_cmdData,
   input  logic [LEN_W-1:0] i_cmdLen,
   output logic             o_rspValid,
   input  logic             i_rspReady,
   output logic [15:0]      o_rspData,
   output logic [13:0]      o_rspAddr,
   output logic             o_done,
   output logic [13:0]      o_memAddr,
   output logic [15:0]      o_memDataOut,
   output logic             o_memWrEn,
   input  logic [15:0]      i_memDataIn
);

   localparam int unsigned ADDR_W    = 14;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned WAIT_W    = 2;
   localparam int unsigned WAIT_INIT = (RD_LATENCY > 0) ? (RD_LATENCY - 1) : 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RADDR,
      ST_RWAIT,
      ST_RRSP
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_data_q;
   logic                mem_wr_en_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic [ADDR_W-1:0]   rsp_addr_q;
   logic                done_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                abort_pend_q;

   logic [ADDR_W-1:0]   addr_d;
   logic [LEN_W-1:0]    cnt_d;
   logic                last_c;
   logic                abort_c;

`ifdef MEM_BUS_INITIATOR_ABORT_EN
   assign abort_c = i_abort;
`else
   assign abort_c = 1'b0;
`endif

   // Address wraps modulo 2^14; the length counter never underflows since 0 ends the burst.
   always_comb begin
      addr_d = mem_addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - LEN_W'(1);
      last_c = (cnt_q == '0);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_wr_en_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_addr_q   <= '0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
         wait_q       <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_cmdValid) begin
                  mem_addr_q   <= i_cmdAddr;
                  cnt_q        <= i_cmdLen;
                  abort_pend_q <= 1'b0;
                  if (i_cmdWrite) begin
                     mem_data_q  <= i_cmdData;
                     mem_wr_en_q <= 1'b1;
                     state_q     <= ST_WRITE;
                  end else begin
                     state_q <= ST_RADDR;
                  end
               end
            end
            ST_WRITE: begin
               if (last_c || abort_c) begin
                  mem_wr_en_q <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  mem_addr_q <= addr_d;
                  cnt_q      <= cnt_d;
               end
            end
            ST_RADDR: begin
               if (abort_c) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (RD_LATENCY == 0) begin
                  rsp_data_q  <= i_memDataIn;
                  rsp_addr_q  <= mem_addr_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RRSP;
               end else begin
                  wait_q  <= WAIT_W'(WAIT_INIT);
                  state_q <= ST_RWAIT;
               end
            end
            ST_RWAIT: begin
               if (abort_c) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (wait_q == '0) begin
                  rsp_data_q  <= i_memDataIn;
                  rsp_addr_q  <= mem_addr_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RRSP;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end
            ST_RRSP: begin
               // An abort seen while waiting for the consumer is honoured after the handshake.
               if (abort_c) begin
                  abort_pend_q <= 1'b1;
               end
               if (i_rspReady) begin
                  rsp_valid_q <= 1'b0;
                  if (last_c || abort_pend_q || abort_c) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     mem_addr_q <= addr_d;
                     cnt_q      <= cnt_d;
                     state_q    <= ST_RADDR;
                  end
               end
            end
            default: begin
               mem_wr_en_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cmdReady   = (state_q == ST_IDLE);
   assign o_rspValid   = rsp_valid_q;
   assign o_rspData    = rsp_data_q;
   assign o_rspAddr    = rsp_addr_q;
   assign o_done       = done_q;
   assign o_memAddr    = mem_addr_q;
   assign o_memDataOut = mem_data_q;
   assign o_memWrEn    = mem_wr_en_q;

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
Memory-bus initiator (bus master) that drives the 14-bit address / 16-bit data memory bus on which the mapped registers and RAM respond. It accepts a single command through a valid/ready handshake: read burst, or write-fill burst. It then sequences the bus (address, write enable, read-data capture) with address auto-increment. Read words are returned on a backpressured response port. Used by the debug/boot loader path to peek, poke and clear memory and mapped registers.

Parameters:
RD_LATENCY, 1, cycles from o_memAddr valid to i_memDataIn valid (legal 0..3; 0 = combinational responder).
LEN_W, 8, width of burst length field.

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rstn  in  1  asynchronous active-low reset
i_cmdValid  in  1  command offered
o_cmdReady  out  1  high only in IDLE; command accepted when i_cmdValid & o_cmdReady
i_cmdWrite  in  1  1 = write-fill burst, 0 = read burst
i_cmdAddr  in  14  start word address
i_cmdData  in  16  fill data (writes only)
i_cmdLen  in  LEN_W  word count minus one (0 = 1 word, 255 = 256 words)
o_rspValid  out  1  read word available
i_rspReady  in  1  response consumed when o_rspValid & i_rspReady
o_rspData  out  16  captured read data
o_rspAddr  out  14  address the read word came from
o_done  out  1  one-cycle pulse when the last word of any command completes
o_memAddr  out  14  bus address
o_memDataOut  out  16  bus write data
o_memWrEn  out  1  bus write strobe, one word per cycle high
i_memDataIn  in  16  bus read data

Behaviour:
- Reset (i_rstn low, asynchronous): state IDLE; o_memAddr=0, o_memDataOut=0, o_memWrEn=0, o_rspValid=0, o_rspData=0, o_rspAddr=0, o_done=0, internal counters=0. o_cmdReady=1 while in reset and after release.
- All bus outputs are registered. In IDLE, o_memWrEn=0; o_memAddr and o_memDataOut hold their last values.
- States: IDLE, WRITE, RADDR, RWAIT, RRSP.
- IDLE: on accept, latch addr/data/len. Write -> WRITE; read -> RADDR. Accept is ignored in any other state (o_cmdReady=0).
- WRITE: o_memWrEn=1, o_memDataOut=fill data. o_memAddr starts at i_cmdAddr and increments by 1 each cycle for len+1 consecutive cycles. The last cycle raises o_done on the following cycle, returning to IDLE. Write throughput: 1 word/cycle; first strobe is the cycle after accept.
- RADDR: o_memAddr=current address, o_memWrEn=0. If RD_LATENCY=0, capture i_memDataIn at this edge and go to RRSP; else go to RWAIT.
- RWAIT: counts RD_LATENCY-1 further cycles holding the address, then captures i_memDataIn into o_rspData and current address into o_rspAddr, then goes to RRSP.
- RRSP: o_rspValid=1, data/addr stable until handshake.
  - On handshake: if words remain, increment address and go to RADDR; else pulse o_done and go to IDLE.
  - o_rspValid drops the cycle after handshake.
- Address arithmetic: 14-bit modulo; 0x3FFF + 1 wraps to 0x0000, and the burst continues without error.
- Length counter: LEN_W-bit down-counter; burst ends when it reaches 0 after the current word (no underflow).
- Reset mid-burst: burst abandoned immediately, o_memWrEn drops asynchronously with reset, no o_done.
- i_rspReady held low stalls indefinitely in RRSP; the bus address stays stable, with no writes.
- Command inputs are don't-care except at the accept edge.

Optional Feature:
Macro MEM_BUS_INITIATOR_ABORT_EN.
- Defined: adds port i_abort (in, 1).
  - i_abort high in WRITE: the current strobe completes, then the FSM goes to IDLE with o_done pulse.
  - i_abort high in RADDR/RWAIT: read discarded, FSM goes to IDLE with o_done pulse, no o_rspValid.
  - i_abort high in RRSP: takes effect after the pending handshake.
  - Ignored in IDLE.
- Undefined: port absent; bursts always run to completion.

Test Plan:
- Reset then write cmd addr=0x0010 data=0xBEEF len=3 -> o_memWrEn high 4 cycles at 0x0010..0x0013 with data 0xBEEF, o_done pulse next cycle, o_cmdReady back to 1.
- RD_LATENCY=1 model, read addr=0x0002 len=1, memory returns addr^0xA5A5, i_rspReady=1 -> rsp 0xA5A7@0x0002 then 0xA5A6@0x0003, one o_done.
- Read len=0 with i_rspReady low 10 cycles -> o_rspValid held, o_rspData stable, o_memWrEn 0 throughout; completes 1 cycle after ready rises.
- Write addr=0x3FFE len=3 data=0x0000 -> strobes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Assert i_rstn low during 3rd word of 8-word write -> o_memWrEn 0 immediately, all outputs reset values, no o_done; new command accepted after release.
- (ABORT_EN) i_abort during read word 2 of 5 -> exactly 1 response delivered, o_done pulse, FSM in IDLE.
